writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage. Accepts completed instructions from the MEM stage and produces the single write port of the register file.
- ALU results pass straight through. Load results wait for data-memory read data, then get byte/halfword lane selection and sign/zero extension.
- All register-file write signals are registered, and the stage counts retired instructions.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- wb_valid_i  input  1  MEM stage presents an instruction
- wb_ready_o  output  1  stage can accept; combinational, high only in IDLE
- wb_reg_write_i  input  1  instruction writes rd
- wb_rd_i  input  5  destination register
- wb_is_load_i  input  1  instruction is a load
- wb_funct3_i  input  3  load width/sign code
- wb_alu_result_i  input  32  ALU result; for loads, the effective address
- dmem_rvalid_i  input  1  data-memory read data valid
- dmem_rdata_i  input  32  data-memory word (aligned word containing the address)
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  register-file write address
- rf_wdata_o  output  32  register-file write data
- load_err_o  output  1  one-cycle pulse: misaligned or illegal load
- instret_o  output  32  retired-instruction count

Behaviour:
- Reset (rst_n=0 at posedge):
  - state returns to IDLE.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, load_err_o=0, instret_o=0.
  - Any pending load is discarded.
- States: IDLE, WAIT_LOAD.
- Handshake: transfer when wb_valid_i && wb_ready_o at a posedge. wb_ready_o = (state==IDLE).
- IDLE, transfer of a non-load at edge N:
  - In cycle N+1: rf_we_o = wb_reg_write_i && (wb_rd_i!=0), rf_waddr_o = wb_rd_i, rf_wdata_o = wb_alu_result_i.
  - instret_o increments at edge N.
  - Back-to-back transfers are allowed every cycle.
- IDLE, transfer of a load at edge N:
  - Latch rd, reg_write, funct3 and addr[1:0]; go to WAIT_LOAD.
  - rf_we_o=0 in cycle N+1.
- WAIT_LOAD:
  - wb_ready_o=0.
  - At the first edge M with dmem_rvalid_i=1: format the data, drive rf_* in cycle M+1, return to IDLE, increment instret_o.
  - A new transfer is possible from edge M+1 onward.
- dmem_rvalid_i in IDLE is ignored.
- Load formatting, with byte lane = addr[1:0] and halfword lane = addr[1]:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected halfword; requires addr[0]=0.
  - 101 LHU: zero-extend the selected halfword; requires addr[0]=0.
  - 010 LW: full word; requires addr[1:0]=0.
- Misaligned access or funct3 in {011,110,111}:
  - Checked at transfer.
  - The stage still waits in WAIT_LOAD for dmem_rvalid_i.
  - In cycle M+1: rf_we_o=0 and load_err_o=1 for one cycle; instret_o still increments.
- rd=0: rf_we_o stays 0 for all instruction types; instret_o still increments.
- rf_we_o is high for exactly one cycle per writing instruction. rf_waddr_o/rf_wdata_o hold their last values when rf_we_o=0.
- instret_o wraps from 0xFFFFFFFF to 0.
- Reset while in WAIT_LOAD: no write, no count, state IDLE. An rvalid in the reset cycle is ignored.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: on every cycle with rf_we_o=1, print simulation time, x<rd> and data in hex. On every load_err_o pulse, print time, funct3 and addr.
- Undefined: no display statements compiled; functional behaviour is identical.

Test Plan:
- Reset, then valid non-load rd=5, ALU=0x12345678, reg_write=1 -> next cycle rf_we_o=1, waddr=5, wdata=0x12345678; instret_o=1.
- Three back-to-back ALU ops to x1,x2,x3 with wb_valid_i held high -> three consecutive rf_we_o pulses in order; wb_ready_o never drops.
- LB at addr ending 2'b11, rdata=0x80FF7F01 with rvalid 3 cycles later -> wb_ready_o=0 while waiting; then wdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH at addr[1:0]=2'b10, rdata=0x8001_1234 -> wdata=0xFFFF8001. LW at addr[1:0]=2'b01 -> no write, load_err_o one-cycle pulse, instret_o increments.
- ALU op with rd=0, data 0xDEADBEEF -> rf_we_o stays 0, instret_o increments. Preload instret_o to 0xFFFFFFFF by retiring 2^32−1 instructions (long sim) -> next retirement reads 0.
- Accept a load, assert rst_n=0 together with dmem_rvalid_i=1 -> no write; state IDLE; wb_ready_o=1 after reset; instret_o=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: registers the register-file write port, formats load data, counts retirements.
// Optional define WB_TRACE_EN prints every register write and every load error.
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic            wb_reg_write_i,
    input  logic [4:0]      wb_rd_i,
    input  logic            wb_is_load_i,
    input  logic [2:0]      wb_funct3_i,
    input  logic [XLEN-1:0] wb_alu_result_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            load_err_o,
    output logic [31:0]     instret_o
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

    wb_state_e       state_r;
    wb_state_e       state_nxt_s;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic [2:0]      funct3_r;
    logic [1:0]      addr_lo_r;
    logic            err_r;
    logic            rf_we_r;
    logic [4:0]      rf_waddr_r;
    logic [XLEN-1:0] rf_wdata_r;
    logic            load_err_r;
    logic [31:0]     instret_r;
    logic            ready_s;
    logic            xfer_s;
    logic [XLEN-1:0] load_data_s;

    // Alignment/encoding check for a load; done at transfer time on the live inputs.
    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Lane selection plus sign/zero extension of the returned memory word.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'd0;
        endcase
        if (a[1]) begin
            h = w[31:16];
        end else begin
            h = w[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign ready_s     = (state_r == ST_IDLE);
    assign xfer_s      = wb_valid_i && ready_s;
    assign load_data_s = format_load(funct3_r, addr_lo_r, dmem_rdata_i);

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && wb_is_load_i) begin
                    state_nxt_s = ST_WAIT_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_LOAD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, pending-load context and registered write port; write pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rd_r        <= 5'd0;
            reg_write_r <= 1'b0;
            funct3_r    <= 3'd0;
            addr_lo_r   <= 2'd0;
            err_r       <= 1'b0;
            rf_we_r     <= 1'b0;
            rf_waddr_r  <= 5'd0;
            rf_wdata_r  <= 32'd0;
            load_err_r  <= 1'b0;
            instret_r   <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            rf_we_r    <= 1'b0;
            load_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s && wb_is_load_i) begin
                        rd_r        <= wb_rd_i;
                        reg_write_r <= wb_reg_write_i;
                        funct3_r    <= wb_funct3_i;
                        addr_lo_r   <= wb_alu_result_i[1:0];
                        err_r       <= load_illegal(wb_funct3_i, wb_alu_result_i[1:0]);
                    end else if (xfer_s) begin
                        instret_r <= instret_r + 32'd1;
                        if (wb_reg_write_i && (wb_rd_i != 5'd0)) begin
                            rf_we_r    <= 1'b1;
                            rf_waddr_r <= wb_rd_i;
                            rf_wdata_r <= wb_alu_result_i;
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (dmem_rvalid_i) begin
                        instret_r <= instret_r + 32'd1;
                        if (err_r) begin
                            load_err_r <= 1'b1;
                        end else if (reg_write_r && (rd_r != 5'd0)) begin
                            rf_we_r    <= 1'b1;
                            rf_waddr_r <= rd_r;
                            rf_wdata_r <= load_data_s;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_TRACE_EN
    // Simulation trace of register writes and load faults.
    always_ff @(posedge clk) begin
        if (rf_we_r) begin
            $display("%0t WB x%0d <= %h", $time, rf_waddr_r, rf_wdata_r);
        end
        if (load_err_r) begin
            $display("%0t WB load error funct3=%b addr[1:0]=%b", $time, funct3_r, addr_lo_r);
        end
    end
`endif

    assign wb_ready_o = ready_s;
    assign rf_we_o    = rf_we_r;
    assign rf_waddr_o = rf_waddr_r;
    assign rf_wdata_o = rf_wdata_r;
    assign load_err_o = load_err_r;
    assign instret_o  = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes/errors are queued at stimulus and
// popped when the DUT drives rf_we_o or load_err_o.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_i;
    logic        wb_is_load_i;
    logic [2:0]  wb_funct3_i;
    logic [31:0] wb_alu_result_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        load_err_o;
    logic [31:0] instret_o;

    typedef struct {
        logic        err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks_r;
    int          errors_r;
    logic [31:0] exp_instret_r;
    logic [31:0] last_wdata_r;

    writeback_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i),
        .wb_is_load_i(wb_is_load_i), .wb_funct3_i(wb_funct3_i),
        .wb_alu_result_i(wb_alu_result_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .load_err_o(load_err_o), .instret_o(instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_illegal(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a[0] == 1'b1);
        if (f3 == 3'b010) return (a != 2'b00);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * a);
        sh = w >> (16 * a[1]);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'd0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Output monitor: each write or error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rf_we_o === 1'b1 || load_err_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", {30'd0, rf_we_o, load_err_o}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_kind", {30'd0, rf_we_o, load_err_o}, {30'd0, ~e.err, e.err});
                if (!e.err) begin
                    check("waddr", {27'd0, rf_waddr_o}, {27'd0, e.addr});
                    check("wdata", rf_wdata_o, e.data);
                end
            end
        end
    end

    task automatic push_write(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        if (rw && rd != 5'd0) begin
            e.err = 1'b0; e.addr = rd; e.data = d;
            sb_q.push_back(e);
            last_wdata_r = d;
        end
    endtask

    task automatic do_alu(input logic rw, input logic [4:0] rd, input logic [31:0] d);
        wb_valid_i = 1'b1; wb_is_load_i = 1'b0; wb_reg_write_i = rw;
        wb_rd_i = rd; wb_alu_result_i = d; wb_funct3_i = 3'b010;
        check("alu_ready", {31'd0, wb_ready_o}, 32'd1);
        @(posedge clk);
        push_write(rw, rd, d);
        exp_instret_r = exp_instret_r + 32'd1;
        #1;
        wb_valid_i = 1'b0;
        check("alu_instret", instret_o, exp_instret_r);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] w, input int delay);
        exp_t e;
        wb_valid_i = 1'b1; wb_is_load_i = 1'b1; wb_reg_write_i = 1'b1;
        wb_rd_i = rd; wb_funct3_i = f3; wb_alu_result_i = addr;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0; wb_is_load_i = 1'b0;
        check("ld_ready_low", {31'd0, wb_ready_o}, 32'd0);
        for (int i = 1; i < delay; i++) begin
            @(posedge clk);
            #1;
            check("ld_wait_ready", {31'd0, wb_ready_o}, 32'd0);
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = w;
        if (exp_illegal(f3, addr[1:0])) begin
            e.err = 1'b1; e.addr = 5'd0; e.data = 32'd0;
            sb_q.push_back(e);
        end else begin
            push_write(1'b1, rd, exp_load(f3, addr[1:0], w));
        end
        exp_instret_r = exp_instret_r + 32'd1;
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b0;
        check("ld_ready_back", {31'd0, wb_ready_o}, 32'd1);
        check("ld_instret", instret_o, exp_instret_r);
    endtask

    initial begin
        checks_r = 0; errors_r = 0; exp_instret_r = 32'd0; last_wdata_r = 32'd0;
        rst_n = 1'b0; wb_valid_i = 1'b0; wb_reg_write_i = 1'b0; wb_rd_i = 5'd0;
        wb_is_load_i = 1'b0; wb_funct3_i = 3'd0; wb_alu_result_i = 32'd0;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {31'd0, rf_we_o}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        check("rst_wdata", rf_wdata_o, 32'd0);
        check("rst_err", {31'd0, load_err_o}, 32'd0);
        check("rst_instret", instret_o, 32'd0);
        check("rst_ready", {31'd0, wb_ready_o}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_alu(1'b1, 5'd5, 32'h1234_5678);

        // Back-to-back ALU ops with valid held high.
        wb_valid_i = 1'b1; wb_is_load_i = 1'b0; wb_reg_write_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wb_rd_i = 5'(i);
            wb_alu_result_i = 32'hA000_0000 + 32'(i);
            check("b2b_ready", {31'd0, wb_ready_o}, 32'd1);
            @(posedge clk);
            push_write(1'b1, 5'(i), 32'hA000_0000 + 32'(i));
            exp_instret_r = exp_instret_r + 32'd1;
            #1;
        end
        wb_valid_i = 1'b0;
        check("b2b_instret", instret_o, exp_instret_r);

        do_load(5'd7,  3'b000, 32'h0000_1003, 32'h80FF_7F01, 3);
        do_load(5'd8,  3'b100, 32'h0000_1003, 32'h80FF_7F01, 3);
        do_load(5'd9,  3'b000, 32'h0000_1001, 32'h80FF_7F01, 1);
        do_load(5'd10, 3'b001, 32'h0000_2002, 32'h8001_1234, 2);
        do_load(5'd11, 3'b101, 32'h0000_2002, 32'h8001_1234, 1);
        do_load(5'd12, 3'b001, 32'h0000_2000, 32'h8001_9234, 1);
        do_load(5'd13, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 2);
        do_load(5'd14, 3'b010, 32'h0000_3001, 32'hCAFE_F00D, 2);
        do_load(5'd15, 3'b001, 32'h0000_3001, 32'hCAFE_F00D, 1);
        do_load(5'd16, 3'b011, 32'h0000_3000, 32'hCAFE_F00D, 1);
        do_load(5'd17, 3'b110, 32'h0000_3000, 32'hCAFE_F00D, 1);
        check("err_hold_wdata", rf_wdata_o, last_wdata_r);

        do_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("rd0_hold_wdata", rf_wdata_o, last_wdata_r);
        do_alu(1'b0, 5'd20, 32'h5555_AAAA);
        do_load(5'd0, 3'b010, 32'h0000_4000, 32'h1111_2222, 1);

        // rvalid while idle must be ignored.
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b0;
        check("idle_rvalid_instret", instret_o, exp_instret_r);

        // Reset arriving together with rvalid while a load is pending.
        wb_valid_i = 1'b1; wb_is_load_i = 1'b1; wb_reg_write_i = 1'b1;
        wb_rd_i = 5'd21; wb_funct3_i = 3'b010; wb_alu_result_i = 32'h0000_5000;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0; wb_is_load_i = 1'b0;
        rst_n = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h9999_9999;
        @(posedge clk);
        #1;
        rst_n = 1'b1; dmem_rvalid_i = 1'b0;
        exp_instret_r = 32'd0; last_wdata_r = 32'd0;
        check("rstw_ready", {31'd0, wb_ready_o}, 32'd1);
        check("rstw_instret", instret_o, 32'd0);
        check("rstw_we", {31'd0, rf_we_o}, 32'd0);
        check("rstw_wdata", rf_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        check("rstw_ready2", {31'd0, wb_ready_o}, 32'd1);

        do_alu(1'b1, 5'd31, 32'h0BAD_CAFE);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
